// File: rtl/keccak_msg_feeder.sv
// keccak_msg_feeder: packs a byte stream into big-endian 32-bit words
// and drives the keccak core input protocol (reset, words, padding hints).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   s_byte/s_valid/s_last message byte stream; s_empty marks a
//   s_empty/s_ready       zero-length message together with s_last
//   core_reset            per-message core reset (also follows reset)
//   core_in               word to core, first byte in [31:24]
//   core_in_ready         core_in valid
//   core_is_last          final word of the message
//   core_byte_num         valid bytes in the final word (0..3)
//   core_buffer_full      core backpressure
//   core_out_ready        core digest valid
//   busy, done            message in progress / digest-ready pulse
//   byte_count            bytes accepted for the current message
module keccak_msg_feeder #(
  parameter int CLR_CYCLES = 1,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_byte,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_empty,
  output logic             s_ready,
  output logic             core_reset,
  output logic [31:0]      core_in,
  output logic             core_in_ready,
  output logic             core_is_last,
  output logic [1:0]       core_byte_num,
  input  logic             core_buffer_full,
  input  logic             core_out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_count
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_COLLECT,
    S_PRESENT,
    S_PRESENT_LAST,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]      word_q;
  logic [1:0]       k_q;
  logic [1:0]       bnum_q;
  logic             pad_q;
  logic [CW-1:0]    clr_q;
  logic [LEN_W-1:0] cnt_q;

  logic take;
  logic consume;
  logic clr_end;

  assign take    = s_valid & s_ready;
  assign consume = core_in_ready & ~core_buffer_full;
  assign clr_end = (clr_q == CLR_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    s_ready       = 1'b0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = 2'd0;
    busy          = 1'b0;
    done          = 1'b0;
    core_reset    = reset;
    core_in       = word_q;
    byte_count    = cnt_q;
    case (state)
      S_IDLE: begin
        if (s_valid) state_nx = S_CLR;
      end
      S_CLR: begin
        busy       = 1'b1;
        core_reset = 1'b1;
        if (clr_end) state_nx = S_COLLECT;
      end
      S_COLLECT: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (take) begin
          if (s_last && s_empty)
            state_nx = S_PRESENT_LAST;
          else if (s_last)
            state_nx = (k_q == 2'd3) ? S_PRESENT : S_PRESENT_LAST;
          else if (k_q == 2'd3)
            state_nx = S_PRESENT;
        end
      end
      S_PRESENT: begin
        busy          = 1'b1;
        core_in_ready = 1'b1;
        if (consume)
          state_nx = pad_q ? S_PRESENT_LAST : S_COLLECT;
      end
      S_PRESENT_LAST: begin
        busy          = 1'b1;
        core_in_ready = 1'b1;
        core_is_last  = 1'b1;
        core_byte_num = bnum_q;
        if (consume) state_nx = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (core_out_ready) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      k_q    <= '0;
      bnum_q <= '0;
      pad_q  <= 1'b0;
      clr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_valid) begin
            word_q <= '0;
            k_q    <= '0;
            bnum_q <= '0;
            pad_q  <= 1'b0;
            clr_q  <= '0;
            cnt_q  <= '0;
          end
        end
        S_CLR: begin
          if (!clr_end) clr_q <= clr_q + 1'b1;
        end
        S_COLLECT: begin
          if (take) begin
            if (s_last && s_empty) begin
              // close the message without this byte
              bnum_q <= k_q;
              if (k_q == 2'd0) word_q <= '0;
            end else begin
              case (k_q)
                2'd0: word_q <= {s_byte, 24'h0};
                2'd1: word_q[23:16] <= s_byte;
                2'd2: word_q[15:8]  <= s_byte;
                default: word_q[7:0] <= s_byte;
              endcase
              k_q <= k_q + 2'd1;
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
              if (s_last) begin
                // a full final word still needs an empty pad word
                bnum_q <= k_q + 2'd1;
                pad_q  <= (k_q == 2'd3);
              end
            end
          end
        end
        S_PRESENT: begin
          if (consume && pad_q) begin
            word_q <= '0;
            bnum_q <= '0;
            pad_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
